// File: rtl/modexp_seq.sv
// Modular exponentiation sequencer: drives one external Montgomery multiplier
// through a left-to-right square-and-multiply schedule with domain conversion.
module modexp_seq #(
  parameter int unsigned WIDTH    = 260,
  parameter int unsigned EXP_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [EXP_BITS-1:0] exp,
  input  logic [WIDTH-1:0]    m,
  input  logic [WIDTH-1:0]    r2,
  output logic [WIDTH-1:0]    result,
  output logic                done,
  output logic                mm_start,
  output logic [WIDTH-1:0]    mm_a,
  output logic [WIDTH-1:0]    mm_b,
  output logic [WIDTH-1:0]    mm_m,
  input  logic                mm_done,
  input  logic [WIDTH-1:0]    mm_result
);

  localparam int unsigned IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PREP  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [2:0] P_BM  = 3'd0;
  localparam logic [2:0] P_ACC = 3'd1;
  localparam logic [2:0] P_SQR = 3'd2;
  localparam logic [2:0] P_MUL = 3'd3;
  localparam logic [2:0] P_FIN = 3'd4;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]    base_q, base_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WIDTH-1:0]    r2_q, r2_d;
  logic [WIDTH-1:0]    bm_q, bm_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                done_q, done_d;
  logic                mm_start_q, mm_start_d;
  logic [WIDTH-1:0]    mm_a_q, mm_a_d;
  logic [WIDTH-1:0]    mm_b_q, mm_b_d;
  logic [WIDTH-1:0]    mm_m_q, mm_m_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    base_d     = base_q;
    exp_d      = exp_q;
    m_d        = m_q;
    r2_d       = r2_q;
    bm_d       = bm_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done_d     = done_q;
    mm_start_d = mm_start_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_m_d     = mm_m_q;

    case (state_q)
      S_IDLE: begin
        done_d = !start;
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          m_d     = m;
          r2_d    = r2;
          phase_d = P_BM;
          idx_d   = '0;
          state_d = S_PREP;
        end
      end

      // Operands only move here, so they are stable for the whole multiply.
      S_PREP: begin
        if (mm_done) begin
          mm_m_d = m_q;
          case (phase_q)
            P_BM:    begin mm_a_d = base_q; mm_b_d = r2_q;  end
            P_ACC:   begin mm_a_d = r2_q;   mm_b_d = ONE;   end
            P_SQR:   begin mm_a_d = acc_q;  mm_b_d = acc_q; end
            P_MUL:   begin mm_a_d = acc_q;  mm_b_d = bm_q;  end
            default: begin mm_a_d = acc_q;  mm_b_d = ONE;   end
          endcase
          mm_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!mm_done) begin
          mm_start_d = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mm_done) begin
          state_d = S_PREP;
          case (phase_q)
            P_BM: begin
              bm_d    = mm_result;
              phase_d = P_ACC;
            end
            P_ACC: begin
              acc_d   = mm_result;
              idx_d   = IW'(EXP_BITS - 1);
              phase_d = P_SQR;
            end
            P_SQR: begin
              acc_d = mm_result;
              if (exp_q[idx_q])
                phase_d = P_MUL;
              else if (idx_q == '0)
                phase_d = P_FIN;
              else
                idx_d = idx_q - IW'(1);
            end
            P_MUL: begin
              acc_d = mm_result;
              if (idx_q == '0) begin
                phase_d = P_FIN;
              end else begin
                idx_d   = idx_q - IW'(1);
                phase_d = P_SQR;
              end
            end
            default: begin
              result_d = mm_result;
              done_d   = 1'b1;
              state_d  = S_IDLE;
            end
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= P_BM;
      idx_q      <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      m_q        <= '0;
      r2_q       <= '0;
      bm_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      m_q        <= m_d;
      r2_q       <= r2_d;
      bm_q       <= bm_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_m_q     <= mm_m_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq: behavioural Montgomery multiplier with variable latency,
// plain modular-exponentiation reference model, and directed command vectors.
module tb_modexp_seq;

  localparam int unsigned WIDTH    = 260;
  localparam int unsigned EXP_BITS = 256;
  localparam int unsigned MAX_WAIT = 40000;

  typedef logic [WIDTH-1:0]     word_t;
  typedef logic [EXP_BITS-1:0]  ex_t;
  typedef logic [2*WIDTH+1:0]   wide_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  logic  start = 1'b0;
  word_t base  = '0;
  ex_t   exp   = '0;
  word_t m     = '0;
  word_t r2    = '0;
  word_t result, mm_a, mm_b, mm_m, mm_result;
  logic  done, mm_start, mm_done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          chk_en = 1'b0;
  word_t       exp_res = '0;
  bit          lat_mode = 1'b0;

  always #5 clk = ~clk;

  modexp_seq #(.WIDTH(WIDTH), .EXP_BITS(EXP_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exp(exp), .m(m), .r2(r2),
    .result(result), .done(done), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_m(mm_m), .mm_done(mm_done), .mm_result(mm_result)
  );

  // a*b*2^-EXP_BITS mod m via bitwise REDC
  function automatic word_t mont(input word_t a, input word_t b, input word_t md);
    wide_t t;
    t = wide_t'(a) * wide_t'(b);
    for (int i = 0; i < EXP_BITS; i++) begin
      if (t[0]) t = t + wide_t'(md);
      t = t >> 1;
    end
    if (t >= wide_t'(md)) t = t - wide_t'(md);
    return word_t'(t);
  endfunction

  function automatic word_t mod_exp(input word_t b, input ex_t e, input word_t md);
    wide_t r, x, mw;
    mw = wide_t'(md);
    r  = wide_t'(1) % mw;
    x  = wide_t'(b) % mw;
    for (int i = 0; i < EXP_BITS; i++) begin
      if (e[i]) r = (r * x) % mw;
      x = (x * x) % mw;
    end
    return word_t'(r);
  endfunction

  function automatic word_t calc_r2(input word_t md);
    wide_t t;
    t = '0;
    t[2*EXP_BITS] = 1'b1;
    t = t % wide_t'(md);
    return word_t'(t);
  endfunction

  function automatic int unsigned pick_lat();
    if (!lat_mode) return $urandom_range(1, 4);
    if ($urandom_range(0, 15) == 0) return $urandom_range(1, 300);
    return $urandom_range(1, 8);
  endfunction

  // Multiplier model: mm_done high while idle, low while busy
  logic        mm_busy;
  int unsigned mm_cnt;
  word_t       cap_a, cap_b, cap_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_busy   <= 1'b0;
      mm_done   <= 1'b0;
      mm_cnt    <= 0;
      mm_result <= '0;
    end else if (mm_busy) begin
      if (mm_cnt <= 1) begin
        mm_busy   <= 1'b0;
        mm_done   <= 1'b1;
        mm_result <= mont(cap_a, cap_b, cap_m);
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end else if (!mm_done) begin
      mm_done <= 1'b1;
    end else if (mm_start) begin
      cap_a   <= mm_a;
      cap_b   <= mm_b;
      cap_m   <= mm_m;
      mm_busy <= 1'b1;
      mm_done <= 1'b0;
      mm_cnt  <= pick_lat();
    end
  end

  int unsigned n_rise  = 0;
  logic        st_prev = 1'b0;
  always @(posedge clk) begin
    if (mm_start && !st_prev) n_rise <= n_rise + 1;
    st_prev <= mm_start;
  end

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic chk(input string nm, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mm_busy) begin
          checks++;
          if (mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m) begin
            errors++;
            $display("FAIL operand_stable: mm_a=%0h mm_b=%0h required a=%0h b=%0h",
                     mm_a, mm_b, cap_a, cap_b);
          end
        end
        if (chk_en && done) begin
          checks++;
          if (result !== exp_res) begin
            errors++;
            $display("FAIL result_vs_model: got %0h required %0h", result, exp_res);
          end
        end
      end
    end
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", nm, MAX_WAIT);
      summary();
    end
  endtask

  task automatic run_cmd(input string nm, input word_t b, input ex_t e, input word_t md,
                         input word_t lit, input bit disturb);
    int unsigned r0;
    wait_done({nm, "_ready"});
    base  = b;
    exp   = e;
    m     = md;
    r2    = calc_r2(md);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    exp_res = mod_exp(b, e, md);
    chk_en  = 1'b1;
    r0      = n_rise;
    chk({nm, "_model"}, exp_res, lit);
    if (disturb) begin
      repeat (40) @(negedge clk);
      base  = b + word_t'(1);
      exp   = ~e;
      m     = md + word_t'(2);
      r2    = '1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done({nm, "_done"});
    chk({nm, "_result"}, result, lit);
    chk({nm, "_mults"}, word_t'(n_rise - r0), word_t'(3 + EXP_BITS + $countones(e)));
  endtask

  initial begin
    word_t       pm;
    ex_t         ex_b;
    int unsigned r0;
    bit          hit;

    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_done", word_t'(done), '0);
    chk("reset_result", result, '0);
    chk("reset_mm_start", word_t'(mm_start), '0);
    chk("reset_mm_a", mm_a, '0);
    chk("reset_mm_m", mm_m, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_done", word_t'(done), word_t'(1));

    lat_mode = 1'b0;
    run_cmd("pow4_13", word_t'(4), ex_t'(13), word_t'(497), word_t'(445), 1'b0);
    run_cmd("exp0", word_t'(5), ex_t'(0), word_t'(497), word_t'(1), 1'b0);
    run_cmd("exp1", word_t'(5), ex_t'(1), word_t'(497), word_t'(5), 1'b0);

    lat_mode = 1'b1;
    pm = '0;
    pm[255] = 1'b1;
    pm = pm - word_t'(19);
    run_cmd("fermat", word_t'(2), ex_t'(pm) - ex_t'(1), pm, word_t'(1), 1'b0);

    lat_mode = 1'b0;
    run_cmd("busy_start", word_t'(4), ex_t'(13), word_t'(497), word_t'(445), 1'b1);

    // Reset in the middle of a command
    wait_done("rst_ready");
    base  = word_t'(5);
    exp   = '1;
    m     = word_t'(497);
    r2    = calc_r2(word_t'(497));
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    chk_en = 1'b0;
    r0     = n_rise;
    hit    = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (n_rise - r0 >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_reach_mult100", word_t'(hit), word_t'(1));
    reset = 1'b1;
    #1;
    chk("rst_done", word_t'(done), '0);
    chk("rst_mm_start", word_t'(mm_start), '0);
    chk("rst_mm_a", mm_a, '0);
    @(negedge clk);
    reset = 1'b0;
    run_cmd("after_reset", word_t'(4), ex_t'(13), word_t'(497), word_t'(445), 1'b0);

    // Back-to-back with start held high
    ex_b = ex_t'(64'hDEAD_BEEF_0123_4567);
    wait_done("b2b_ready");
    base  = word_t'(3);
    exp   = ex_t'(77);
    m     = word_t'(497);
    r2    = calc_r2(word_t'(497));
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_res = mod_exp(word_t'(3), ex_t'(77), word_t'(497));
    chk_en  = 1'b1;
    r0      = n_rise;
    @(negedge clk);
    base = word_t'(10);
    exp  = ex_b;
    m    = word_t'(1009);
    r2   = calc_r2(word_t'(1009));
    wait_done("b2b_first");
    chk("b2b_first_result", result, exp_res);
    chk("b2b_first_mults", word_t'(n_rise - r0), word_t'(3 + EXP_BITS + $countones(ex_t'(77))));
    @(posedge clk);
    #1;
    chk("b2b_accept_done", word_t'(done), '0);
    exp_res = mod_exp(word_t'(10), ex_b, word_t'(1009));
    r0      = n_rise;
    start   = 1'b0;
    wait_done("b2b_second");
    chk("b2b_second_result", result, exp_res);
    chk("b2b_second_mults", word_t'(n_rise - r0), word_t'(3 + EXP_BITS + $countones(ex_b)));

    repeat (3) @(negedge clk);
    summary();
  end

endmodule
